retire_unit: RTL and testbench

// - Commit stage directly downstream of the reorder buffer: consumes up to 3 in-order completed entries/cycle from the ROB output bus.
// - Updates the committed (retirement) register alias table (RRAT) and releases each overwritten physical tag to the rename free list.
// - Throttles the ROB via a ready count so that a freed tag is never dropped.

---
 rtl/retire_unit.sv | 150 +++++++++++++++
 tb/tb_retire_unit.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/retire_unit.sv
// Commit stage behind the ROB: updates the retirement alias table and queues overwritten tags for the free list.
// Optional RETIRE_PERF_EN adds perf_retired / perf_stall counters.
module retire_unit #(
  parameter int unsigned ENTRY_W     = 10,
  parameter int unsigned PHYS_W      = 5,
  parameter int unsigned ARCH_REGS   = 8,
  parameter int unsigned FREEQ_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [3*ENTRY_W-1:0]          rob_dout,
  output logic [2:0]                    rob_ready_ct,
  output logic [PHYS_W-1:0]             free_tag,
  output logic                          free_valid,
  input  logic                          free_ready,
  output logic [ARCH_REGS*PHYS_W-1:0]   arch_map,
  output logic [1:0]                    retire_ct
`ifdef RETIRE_PERF_EN
  ,
  output logic [31:0]                   perf_retired,
  output logic [31:0]                   perf_stall
`endif
);

  localparam int unsigned AIDX_W = $clog2(ARCH_REGS);
  localparam int unsigned PTR_W  = $clog2(FREEQ_DEPTH);
  localparam int unsigned CNT_W  = $clog2(FREEQ_DEPTH + 1);

  logic [PHYS_W-1:0] rrat_q [ARCH_REGS];
  logic [PHYS_W-1:0] rrat_d [ARCH_REGS];
  logic [PHYS_W-1:0] mem_q  [FREEQ_DEPTH];
  logic [PHYS_W-1:0] mem_d  [FREEQ_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [1:0]        retire_ct_q, retire_ct_d;

  logic [PHYS_W-1:0] push_tag [3];
  logic [1:0]        push_n;
  logic [1:0]        n_valid;
  logic              pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(FREEQ_DEPTH - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  // Walk slots oldest first; the first empty slot closes the group.
  always_comb begin
    logic                group_open;
    logic [ENTRY_W-1:0]  slot;
    logic [AIDX_W-1:0]   arch;
    rrat_d     = rrat_q;
    push_tag   = '{default: '0};
    push_n     = '0;
    n_valid    = '0;
    group_open = 1'b1;
    for (int i = 0; i < 3; i++) begin
      slot = rob_dout[i*ENTRY_W +: ENTRY_W];
      arch = slot[PHYS_W +: AIDX_W];
      if (group_open && slot[ENTRY_W-1]) begin
        n_valid = n_valid + 2'd1;
        if (slot[ENTRY_W-2]) begin
          push_tag[push_n] = rrat_d[arch];
          rrat_d[arch]     = slot[PHYS_W-1:0];
          push_n           = push_n + 2'd1;
        end
      end else begin
        group_open = 1'b0;
      end
    end
  end

  // Freed-tag queue: pushes in slot order, drop when full, pop concurrently.
  always_comb begin
    logic [CNT_W-1:0] n_push;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    n_push   = '0;
    for (int k = 0; k < 3; k++) begin
      if ((2'(k) < push_n) && (32'(count_q) + 32'(n_push) < 32'(FREEQ_DEPTH))) begin
        mem_d[wr_ptr_d] = push_tag[k];
        wr_ptr_d        = ptr_inc(wr_ptr_d);
        n_push          = n_push + CNT_W'(1);
      end
    end
    pop         = free_valid && free_ready;
    rd_ptr_d    = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d     = count_q + n_push - CNT_W'(pop);
    retire_ct_d = n_valid;
  end

  // Grant leaves room for the three entries already in flight.
  always_comb begin
    int avail;
    avail = int'(FREEQ_DEPTH) - int'(count_q) - 3;
    if (!rst)            rob_ready_ct = 3'd0;
    else if (avail <= 0) rob_ready_ct = 3'd0;
    else if (avail >= 3) rob_ready_ct = 3'd3;
    else                 rob_ready_ct = 3'(avail);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < ARCH_REGS; r++) rrat_q[r] <= PHYS_W'(r);
      for (int k = 0; k < FREEQ_DEPTH; k++) mem_q[k] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      retire_ct_q <= '0;
    end else begin
      rrat_q      <= rrat_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      retire_ct_q <= retire_ct_d;
    end
  end

  always_comb begin
    for (int r = 0; r < ARCH_REGS; r++) arch_map[r*PHYS_W +: PHYS_W] = rrat_q[r];
  end

  assign free_tag   = mem_q[rd_ptr_q];
  assign free_valid = (count_q != '0);
  assign retire_ct  = retire_ct_q;

`ifdef RETIRE_PERF_EN
  logic [31:0] perf_retired_q, perf_retired_d, perf_stall_q, perf_stall_d;

  always_comb begin
    perf_retired_d = perf_retired_q + 32'(retire_ct_q);
    perf_stall_d   = perf_stall_q + 32'(rob_ready_ct < 3'd3);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_retired_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      perf_retired_q <= perf_retired_d;
      perf_stall_q   <= perf_stall_d;
    end
  end

  assign perf_retired = perf_retired_q;
  assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_retire_unit.sv
// Scoreboard bench for retire_unit: a grant-respecting ROB driver feeds a queue/array reference model.
module tb_retire_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [29:0] rob_dout;
  logic [2:0]  rob_ready_ct;
  logic [4:0]  free_tag;
  logic        free_valid;
  logic        free_ready;
  logic [39:0] arch_map;
  logic [1:0]  retire_ct;
`ifdef RETIRE_PERF_EN
  logic [31:0] perf_retired, perf_stall;
`endif

  retire_unit dut (
    .clk(clk), .rst(rst), .rob_dout(rob_dout), .rob_ready_ct(rob_ready_ct),
    .free_tag(free_tag), .free_valid(free_valid), .free_ready(free_ready),
    .arch_map(arch_map), .retire_ct(retire_ct)
`ifdef RETIRE_PERF_EN
    , .perf_retired(perf_retired), .perf_stall(perf_stall)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int rrat[8];
  int exp_q[$];
  int last_rc;
  int grant;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [39:0] model_map();
    logic [39:0] m;
    for (int r = 0; r < 8; r++) m[r*5 +: 5] = 5'(rrat[r]);
    return m;
  endfunction

  function automatic logic [39:0] ident_map();
    logic [39:0] m;
    for (int r = 0; r < 8; r++) m[r*5 +: 5] = 5'(r);
    return m;
  endfunction

  function automatic logic [9:0] ent(input int hd, input int a, input int t);
    return {1'b1, 1'(hd), 3'(a), 5'(t)};
  endfunction

  function automatic int exp_ready(input int cnt);
    int v;
    v = 8 - cnt - 3;
    if (v < 0) v = 0;
    if (v > 3) v = 3;
    return v;
  endfunction

  // Random ROB group: at most `g` committing entries, optional gap followed by junk.
  function automatic logic [29:0] gen(input int g, input int dest_pct);
    logic [29:0] d;
    bit stop;
    d = '0;
    stop = 0;
    for (int i = 0; i < 3; i++) begin
      if (!stop && i < g) begin
        if ($urandom_range(0, 7) == 0) stop = 1;
        else d[i*10 +: 10] = ent(($urandom_range(0, 99) < dest_pct) ? 1 : 0,
                                 $urandom_range(0, 7), $urandom_range(0, 31));
      end else if (stop && $urandom_range(0, 1) == 1) begin
        d[i*10 +: 10] = {1'b1, 9'($urandom)};
      end
    end
    return d;
  endfunction

  // Call right after a negedge: check prior commit, present new group, advance the model.
  task automatic step(input bit use_rand, input logic [29:0] din, input int dest_pct);
    logic [29:0] d;
    int rc;
    check("arch_map", 64'(arch_map), 64'(model_map()));
    check("retire_ct", 64'(retire_ct), 64'(last_rc));
    check("rob_ready_ct", 64'(rob_ready_ct), 64'(exp_ready(exp_q.size())));
    check("free_valid", 64'(free_valid), 64'(exp_q.size() != 0));
    d = use_rand ? gen(grant, dest_pct) : din;
    grant = int'(rob_ready_ct);
    rob_dout = d;
    rc = 0;
    for (int i = 0; i < 3; i++) begin
      if (!d[i*10 + 9]) break;
      rc++;
      if (d[i*10 + 8]) begin
        exp_q.push_back(rrat[d[i*10 + 5 +: 3]]);
        rrat[d[i*10 + 5 +: 3]] = int'(d[i*10 +: 5]);
      end
    end
    last_rc = rc;
  endtask

  task automatic model_reset();
    for (int r = 0; r < 8; r++) rrat[r] = r;
    exp_q.delete();
    last_rc = 0;
  endtask

  // Monitor: every accepted pop must match the oldest expected freed tag.
  always begin
    @(negedge clk);
    #1;
    if (rst && free_valid && free_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL free_tag: got %0d expected none (queue model empty)", free_tag);
      end else begin
        check("free_tag", 64'(free_tag), 64'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    rst = 1'b0;
    rob_dout = '0;
    free_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("ready_in_reset", 64'(rob_ready_ct), 64'd0);
    check("valid_in_reset", 64'(free_valid), 64'd0);
    rst = 1'b1;
    #1;
    check("ready_after_reset", 64'(rob_ready_ct), 64'd3);
    check("map_after_reset", 64'(arch_map), 64'(ident_map()));
    grant = 3;

    // Directed groups: single write, triple same-reg write, gap, no-dest.
    @(negedge clk); step(0, {20'd0, ent(1, 0, 9)}, 0);
    @(negedge clk); check("free_tag_first", 64'(free_tag), 64'd0);
    step(0, {ent(1, 1, 12), ent(1, 1, 11), ent(1, 1, 10)}, 0);
    @(negedge clk); step(0, {ent(1, 2, 20), 10'd0, ent(1, 3, 21)}, 0);
    @(negedge clk); step(0, {20'd0, ent(0, 4, 22)}, 0);
    free_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin @(negedge clk); step(0, '0, 0); end

    // Backpressure: full dest traffic with the free list stalled, then drain.
    free_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      step(0, (grant == 3) ? {ent(1, i % 8, 23), ent(1, (i + 3) % 8, 24), ent(1, (i + 5) % 8, 25)} :
              (grant == 2) ? {10'd0, ent(1, (i + 1) % 8, 26), ent(1, (i + 2) % 8, 27)} :
              (grant == 1) ? {20'd0, ent(1, (i + 6) % 8, 28)} : 30'd0, 0);
    end
    free_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin @(negedge clk); step(0, '0, 0); end

    // Randomised traffic with random free-list acceptance.
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      free_ready = ($urandom_range(0, 3) != 0);
      step(1, '0, 70);
    end

    // Reset mid-stream with five queued tags.
    free_ready = 1'b0;
    for (int i = 0; i < 12; i++) begin @(negedge clk); step(0, '0, 0); end
    free_ready = 1'b1;
    for (int i = 0; i < 12 && exp_q.size() != 0; i++) begin @(negedge clk); step(0, '0, 0); end
    free_ready = 1'b0;
    @(negedge clk); step(0, {ent(1, 5, 1), ent(1, 6, 2), ent(1, 7, 3)}, 0);
    @(negedge clk); step(0, {10'd0, ent(1, 0, 4), ent(1, 1, 5)}, 0);
    @(negedge clk); step(0, '0, 0);
    check("queued_before_reset", 64'(exp_q.size()), 64'd5);
    #2;
    rst = 1'b0;
    #1;
    check("reset_free_valid", 64'(free_valid), 64'd0);
    check("reset_map", 64'(arch_map), 64'(ident_map()));
    check("reset_ready", 64'(rob_ready_ct), 64'd0);
    model_reset();
    rob_dout = '0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    grant = int'(rob_ready_ct);
    free_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin @(negedge clk); step(1, '0, 80); end

    // Drain, bounded.
    for (int i = 0; i < 40 && (exp_q.size() != 0 || i < 3); i++) begin @(negedge clk); step(0, '0, 0); end
    @(negedge clk);
    check("drained_model", 64'(exp_q.size()), 64'd0);
    check("drained_valid", 64'(free_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
